// File: rtl/tx_fifo_pkg.sv
// Width helpers shared by the multi-channel TX FIFO and its per-channel pointer block.
package tx_fifo_pkg;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // LSB of channel ch inside the packed level bus
  function automatic int lvl_lsb(input int ch, input int depth);
    return ch * lvl_width(depth);
  endfunction

endpackage

// File: rtl/tx_chan_ptr.sv
// Per-channel write/read pointer pair with empty, full, almost-full and fill-level derivation.
module tx_chan_ptr
  import tx_fifo_pkg::*;
#(
  parameter int  DEPTH    = 16,
  parameter int  AFULL_TH = DEPTH - 2,
  localparam int PTRW     = ptr_width(DEPTH),
  localparam int AW       = PTRW - 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic            rd_en_i,
  output logic [AW-1:0]   waddr_o,
  output logic [AW-1:0]   raddr_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            afull_o,
  output logic [PTRW-1:0] level_o
);

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;

  assign wptr_d = wptr_q + PTRW'(wr_en_i);
  assign rptr_d = rptr_q + PTRW'(rd_en_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // MSB is the wrap bit: equal low bits with differing wrap bits means full
  assign waddr_o = wptr_q[AW-1:0];
  assign raddr_o = rptr_q[AW-1:0];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign level_o = wptr_q - rptr_q;
  assign afull_o = (level_o >= PTRW'(AFULL_TH));

endmodule

// File: rtl/tx_mc_fifo.sv
// Single-clock multi-channel TX FIFO: NUM_CH queues sharing one storage array, sticky ovf/udf.
// Define TX_MC_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module tx_mc_fifo
  import tx_fifo_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  FIFO_DEPTH = 16,
  parameter int  DATA_WIDTH = 8,
  parameter int  AFULL_TH   = FIFO_DEPTH - 2,
  localparam int CHW        = ch_width(NUM_CH),
  localparam int LW         = lvl_width(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [CHW-1:0]       w_ch,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                 rinc,
  input  logic [CHW-1:0]       r_ch,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                 r_valid,
  output logic [NUM_CH-1:0]    wfull,
  output logic [NUM_CH-1:0]    rempty,
  output logic [NUM_CH-1:0]    afull,
  output logic [NUM_CH*LW-1:0] level,
  output logic                 ovf,
  output logic                 udf
);

  localparam int             AW     = LW - 1;
  localparam logic [CHW:0]   CH_LIM = (CHW + 1)'(NUM_CH);

  logic                  w_ch_ok, r_ch_ok, w_acc, r_acc;
  logic [NUM_CH-1:0]     wr_en, rd_en;
  logic [AW-1:0]         waddr [NUM_CH];
  logic [AW-1:0]         raddr [NUM_CH];
  logic [CHW+AW-1:0]     w_addr, r_addr;
  logic [DATA_WIDTH-1:0] mem_q [NUM_CH*FIFO_DEPTH];
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  assign w_ch_ok = ({1'b0, w_ch} < CH_LIM);
  assign r_ch_ok = ({1'b0, r_ch} < CH_LIM);
  // Flags come from registered pointers only, so there is no same-cycle write-to-read bypass
  assign w_acc   = winc && !rst && w_ch_ok && !wfull[w_ch];
  assign r_acc   = rinc && !rst && r_ch_ok && !rempty[r_ch];

  always_comb begin
    wr_en = '0;
    rd_en = '0;
    if (w_acc) wr_en[w_ch] = 1'b1;
    if (r_acc) rd_en[r_ch] = 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tx_chan_ptr #(
      .DEPTH   (FIFO_DEPTH),
      .AFULL_TH(AFULL_TH)
    ) u_ptr (
      .clk_i  (clk),
      .rst_i  (rst),
      .wr_en_i(wr_en[c]),
      .rd_en_i(rd_en[c]),
      .waddr_o(waddr[c]),
      .raddr_o(raddr[c]),
      .empty_o(rempty[c]),
      .full_o (wfull[c]),
      .afull_o(afull[c]),
      .level_o(level[lvl_lsb(c, FIFO_DEPTH) +: LW])
    );
  end

  assign w_addr = {w_ch, waddr[w_ch]};
  assign r_addr = {r_ch, raddr[r_ch]};

  always_ff @(posedge clk) begin
    if (w_acc) mem_q[w_addr] <= w_data;
  end

  assign ovf_d = ovf_q | (winc && !w_acc);
  assign udf_d = udf_q | (rinc && !r_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

`ifdef TX_MC_FIFO_FWFT_EN
  assign r_data  = r_ch_ok ? mem_q[r_addr] : '0;
  assign r_valid = r_ch_ok && !rempty[r_ch];
`else
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q;

  assign r_data_d = r_acc ? mem_q[r_addr] : r_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_acc;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_tx_mc_fifo.sv
// Directed bench for tx_mc_fifo (NUM_CH=4, FIFO_DEPTH=16, AFULL_TH=14); follows TX_MC_FIFO_FWFT_EN.
module tb_tx_mc_fifo;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int DW     = 8;
  localparam int CHW    = 2;
  localparam int LW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              winc;
  logic [CHW-1:0]    w_ch;
  logic [DW-1:0]     w_data;
  logic              rinc;
  logic [CHW-1:0]    r_ch;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic [NUM_CH-1:0] wfull, rempty, afull;
  logic [NUM_CH*LW-1:0] level;
  logic              ovf, udf;

  int errors = 0;
  int checks = 0;

  tx_mc_fifo #(
    .NUM_CH    (NUM_CH),
    .FIFO_DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .AFULL_TH  (14)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .w_ch   (w_ch),
    .w_data (w_data),
    .rinc   (rinc),
    .r_ch   (r_ch),
    .r_data (r_data),
    .r_valid(r_valid),
    .wfull  (wfull),
    .rempty (rempty),
    .afull  (afull),
    .level  (level),
    .ovf    (ovf),
    .udf    (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int c);
    return 32'(level[c*LW +: LW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    winc = 1'b1; w_ch = CHW'(ch); w_data = d;
    tick();
    winc = 1'b0;
  endtask

  task automatic pop(input string tag, input int ch, input logic [DW-1:0] exp);
    r_ch = CHW'(ch);
`ifdef TX_MC_FIFO_FWFT_EN
    #1;
    chk({tag, "_vld"}, 32'(r_valid), 32'd1);
    chk({tag, "_dat"}, 32'(r_data), 32'(exp));
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
`else
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk({tag, "_vld"}, 32'(r_valid), 32'd1);
    chk({tag, "_dat"}, 32'(r_data), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; w_ch = '0; w_data = '0; rinc = 1'b0; r_ch = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rempty", 32'(rempty), 32'hF);
    chk("rst_wfull",  32'(wfull),  32'h0);
    chk("rst_afull",  32'(afull),  32'h0);
    chk("rst_level",  32'(level),  32'h0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_ovf",    32'(ovf), 32'd0);
    chk("rst_udf",    32'(udf), 32'd0);
`ifndef TX_MC_FIFO_FWFT_EN
    chk("rst_rdata",  32'(r_data), 32'h0);
`endif

    // Fill channel 2, then overflow it
    for (int i = 0; i < 15; i++) push(2, DW'(8'h10 + i));
    chk("ch2_15_wfull", 32'(wfull[2]), 32'd0);
    chk("ch2_15_level", lvl(2), 32'd15);
    push(2, 8'h1F);
    chk("ch2_16_wfull", 32'(wfull), 32'h4);
    chk("ch2_16_level", lvl(2), 32'd16);
    chk("ch2_16_afull", 32'(afull), 32'h4);
    chk("ch2_16_ovf",   32'(ovf), 32'd0);
    push(2, 8'hEE);
    chk("ch2_17_ovf",   32'(ovf), 32'd1);
    chk("ch2_17_level", lvl(2), 32'd16);
    for (int i = 0; i < 16; i++) pop("ch2_drain", 2, DW'(8'h10 + i));
    chk("ch2_drained_empty", 32'(rempty), 32'hF);
    chk("ch2_drained_udf",   32'(udf), 32'd0);
`ifndef TX_MC_FIFO_FWFT_EN
    tick();
    chk("hold_rvalid", 32'(r_valid), 32'd0);
    chk("hold_rdata",  32'(r_data), 32'h1F);
`endif

    // Interleaved channels keep per-channel order
    for (int i = 0; i < 4; i++) begin
      push(0, DW'(8'hA0 + i));
      push(3, DW'(8'hB0 + i));
    end
    chk("ilv_level0", lvl(0), 32'd4);
    chk("ilv_level3", lvl(3), 32'd4);
    for (int i = 0; i < 4; i++) pop("ilv_ch3", 3, DW'(8'hB0 + i));
    for (int i = 0; i < 4; i++) pop("ilv_ch0", 0, DW'(8'hA0 + i));
    chk("ilv_rempty", 32'(rempty), 32'hF);

    // Same-channel read+write with one entry queued
    push(1, 8'h11);
    winc = 1'b1; w_ch = 2'd1; w_data = 8'h22; rinc = 1'b1; r_ch = 2'd1;
`ifdef TX_MC_FIFO_FWFT_EN
    #1;
    chk("rw1_head", 32'(r_data), 32'h11);
`endif
    tick();
    winc = 1'b0; rinc = 1'b0;
`ifndef TX_MC_FIFO_FWFT_EN
    chk("rw1_rvalid", 32'(r_valid), 32'd1);
    chk("rw1_rdata",  32'(r_data), 32'h11);
`endif
    chk("rw1_level", lvl(1), 32'd1);
    chk("rw1_udf",   32'(udf), 32'd0);
    pop("rw1_next", 1, 8'h22);

    // Same-channel read+write on an empty channel: read rejected
    winc = 1'b1; w_ch = 2'd1; w_data = 8'h33; rinc = 1'b1; r_ch = 2'd1;
`ifdef TX_MC_FIFO_FWFT_EN
    #1;
    chk("rw0_pre_rvalid", 32'(r_valid), 32'd0);
`endif
    tick();
    winc = 1'b0; rinc = 1'b0;
`ifndef TX_MC_FIFO_FWFT_EN
    chk("rw0_rvalid", 32'(r_valid), 32'd0);
`endif
    chk("rw0_udf",   32'(udf), 32'd1);
    chk("rw0_level", lvl(1), 32'd1);
    pop("rw0_data", 1, 8'h33);

    // Pointer wrap on channel 0
    for (int i = 0; i < 40; i++) begin
      push(0, DW'(8'h40 + i));
      chk("wrap_level", lvl(0), 32'd1);
      pop("wrap", 0, DW'(8'h40 + i));
    end
    chk("wrap_empty", 32'(rempty[0]), 32'd1);
    for (int i = 0; i < 13; i++) push(0, DW'(i));
    chk("af13_afull", 32'(afull[0]), 32'd0);
    push(0, 8'd13);
    chk("af14_afull", 32'(afull[0]), 32'd1);
    chk("af14_level", lvl(0), 32'd14);
    chk("af14_wfull", 32'(wfull[0]), 32'd0);

    // Mid-operation reset with entries queued and a request in flight
    for (int i = 0; i < 5; i++) push(3, DW'(8'hC0 + i));
    chk("pre_rst_level3", lvl(3), 32'd5);
    rst = 1'b1; winc = 1'b1; w_ch = 2'd2; w_data = 8'h77; rinc = 1'b1; r_ch = 2'd3;
    tick();
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    chk("mrst_rempty", 32'(rempty), 32'hF);
    chk("mrst_level",  32'(level), 32'h0);
    chk("mrst_rvalid", 32'(r_valid), 32'd0);
    chk("mrst_afull",  32'(afull), 32'h0);
    chk("mrst_ovf",    32'(ovf), 32'd0);
    chk("mrst_udf",    32'(udf), 32'd0);
    tick();
    chk("mrst_hold_level", 32'(level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
